// File: rtl/div_pkg.sv
// Shared types for the divide16 request dispatcher.
// Holds the dispatch state encoding, the MIN constant and the result flags.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam logic [DIV_WIDTH-1:0] MIN_VAL = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_BYPASS
  } state_e;

  typedef struct packed {
    logic dbz;
    logic ovf;
    logic err;
  } flags_t;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO in front of the divider dispatcher.
// Pointers carry an extra wrap bit so full and empty need no counter.
module div_req_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  // Read and write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/div_dispatch.sv
// Issues queued requests to divide16 one at a time.
// Zero divisor and MIN/-1 are answered locally without the divider.
module div_dispatch
  import div_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int RW = 2 * WIDTH + TAG_W;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [WIDTH-1:0] MinV = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop, slot_free;
  logic [RW-1:0]    head;
  logic [WIDTH-1:0] h_a, h_b;
  logic [TAG_W-1:0] h_tag;
  logic             h_dbz, h_ovf;

  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] div_a_q, div_b_q;
  logic [WIDTH-1:0] byp_q_q, byp_r_q;
  flags_t           byp_f_q;
  logic [CW-1:0]    wd_q;
  logic             wd_hit;

  logic             ld;
  logic [WIDTH-1:0] ld_q, ld_r;
  flags_t           ld_f;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q_q, out_r_q;
  logic [TAG_W-1:0] out_tag_q;
  flags_t           out_f_q;

  assign push     = in_valid && in_ready;
  assign in_ready = !fifo_full;

  div_req_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({in_dividend, in_divisor, in_tag}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {h_a, h_b, h_tag} = head;
  assign h_dbz     = (h_b == '0);
  assign h_ovf     = (h_a == MinV) && (h_b == '1);
  assign slot_free = !out_valid_q || out_ready;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty && slot_free;
  assign wd_hit    = (wd_q == CW'(TIMEOUT - 1));

  // Dispatch sequencing; ARM waits out a stale done from the last op.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) state_d = (h_dbz || h_ovf) ? ST_BYPASS : ST_ISSUE;
      end
      ST_BYPASS: state_d = ST_IDLE;
      ST_ISSUE:  state_d = ST_ARM;
      ST_ARM: begin
        if (wd_hit)         state_d = ST_IDLE;
        else if (!div_done) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_done || wd_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pick what, if anything, lands in the output slot this cycle.
  always_comb begin
    ld   = 1'b0;
    ld_q = byp_q_q;
    ld_r = byp_r_q;
    ld_f = byp_f_q;
    if (state_q == ST_BYPASS) begin
      ld = 1'b1;
    end else if (state_q == ST_WAIT && div_done) begin
      ld   = 1'b1;
      ld_q = div_quotient;
      ld_r = div_remainder;
      ld_f = '0;
    end else if ((state_q == ST_ARM || state_q == ST_WAIT) && wd_hit) begin
      ld   = 1'b1;
      ld_q = '0;
      ld_r = '0;
      ld_f = '{dbz: 1'b0, ovf: 1'b0, err: 1'b1};
    end
  end

  assign out_valid_d = ld ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Capture the popped request: bypass result or divider operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      byp_q_q <= '0;
      byp_r_q <= '0;
      byp_f_q <= '0;
    end else if (pop) begin
      tag_q <= h_tag;
      if (h_dbz) begin
        byp_q_q <= '1;
        byp_r_q <= h_a;
        byp_f_q <= '{dbz: 1'b1, ovf: 1'b0, err: 1'b0};
      end else if (h_ovf) begin
        byp_q_q <= MinV;
        byp_r_q <= '0;
        byp_f_q <= '{dbz: 1'b0, ovf: 1'b1, err: 1'b0};
      end else begin
        div_a_q <= h_a;
        div_b_q <= h_b;
      end
    end
  end

  // Watchdog counts from the start pulse while the divider is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   wd_q <= '0;
    else if (state_q == ST_ISSUE) wd_q <= '0;
    else if (state_q == ST_ARM || state_q == ST_WAIT)
                               wd_q <= wd_q + CW'(1);
  end

  // Output slot; data only moves when a new result loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
      out_f_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (ld) begin
        out_q_q   <= ld_q;
        out_r_q   <= ld_r;
        out_tag_q <= tag_q;
        out_f_q   <= ld_f;
      end
    end
  end

  assign div_start     = (state_q == ST_ISSUE);
  assign div_dividend  = div_a_q;
  assign div_divisor   = div_b_q;
  assign out_valid     = out_valid_q;
  assign out_quotient  = out_q_q;
  assign out_remainder = out_r_q;
  assign out_tag       = out_tag_q;
  assign out_dbz       = out_f_q.dbz;
  assign out_ovf       = out_f_q.ovf;
  assign out_err       = out_f_q.err;

endmodule

// File: tb/tb_div_dispatch.sv
// Bench for div_dispatch with a behavioural divide16 model.
// Expected results come from signed-division rules in a queue.
module tb_div_dispatch;

  localparam int W  = 16;
  localparam int TW = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_dividend = '0;
  logic [W-1:0]  in_divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          div_start;
  logic [W-1:0]  div_dividend, div_divisor;
  logic          div_done = 1'b1;
  logic [W-1:0]  div_quotient = '0;
  logic [W-1:0]  div_remainder = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_quotient, out_remainder;
  logic [TW-1:0] out_tag;
  logic          out_dbz, out_ovf, out_err;

  div_dispatch #(.WIDTH(W), .DEPTH(4), .TAG_W(TW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .in_tag        (in_tag),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_tag       (out_tag),
    .out_dbz       (out_dbz),
    .out_ovf       (out_ovf),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    logic          dbz;
    logic          ovf;
    logic          err;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   cyc = 0;
  int   start_cyc = 0;
  int   starts = 0;
  int   dlat = 5;
  int   dcnt = 0;
  bit   hang = 1'b0;
  bit   drop = 1'b0;
  logic signed [W-1:0] sa = '0, sb = '1;

  // divide16 stand-in: done drops a cycle after start, rises dlat later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) begin
      starts    <= starts + 1;
      start_cyc <= cyc;
      sa        <= div_dividend;
      sb        <= div_divisor;
      dcnt      <= dlat;
      drop      <= 1'b1;
    end else begin
      if (drop) begin
        div_done <= 1'b0;
        drop     <= 1'b0;
      end
      if (dcnt > 0) dcnt <= dcnt - 1;
      if (dcnt == 1 && !hang) begin
        div_done      <= 1'b1;
        div_quotient  <= W'(int'(sa) / int'(sb));
        div_remainder <= W'(int'(sa) % int'(sb));
      end
    end
  end

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] t, input bit err);
    res_t r;
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    r = '0;
    r.tag = t;
    if (err) begin
      r.err = 1'b1;
    end else if (b == '0) begin
      r.q = '1;
      r.r = a;
      r.dbz = 1'b1;
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      r.q = 16'h8000;
      r.ovf = 1'b1;
    end else begin
      r.q = W'(ia / ib);
      r.r = W'(ia % ib);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t, input bit err);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("push_ready", 32'(in_ready), 32'd1);
      return;
    end
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(model(a, b, t, err));
  endtask

  task automatic collect(output int vcyc);
    int n;
    res_t e;
    n = 0;
    vcyc = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_wait", 32'(out_valid), 32'd1);
      return;
    end
    vcyc = cyc;
    if (exp_q.size() == 0) begin
      chk("unexpected_result", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("quotient",  32'(out_quotient),  32'(e.q));
      chk("remainder", 32'(out_remainder), 32'(e.r));
      chk("tag",       32'(out_tag),       32'(e.tag));
      chk("flags", 32'({out_dbz, out_ovf, out_err}),
          32'({e.dbz, e.ovf, e.err}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int s0, vc, k;
    logic [W-1:0]  hq;
    logic [TW-1:0] ht;
    logic [W-1:0]  ra, rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_ops",   32'({div_dividend, div_divisor}), 32'd0);
    chk("rst_out_data",  32'({out_quotient, out_remainder}), 32'd0);
    chk("rst_out_misc",  32'({out_tag, out_dbz, out_ovf, out_err}), 32'd0);

    s0 = starts;
    push(16'd100, 16'd7, 4'd3, 1'b0);
    collect(vc);
    chk("one_start", 32'(starts - s0), 32'd1);

    s0 = starts;
    push(-16'sd100, 16'd7, 4'd5, 1'b0);
    push(16'd100, -16'sd7, 4'd6, 1'b0);
    collect(vc);
    collect(vc);
    chk("two_starts", 32'(starts - s0), 32'd2);

    s0 = starts;
    push(16'd5, 16'd0, 4'd7, 1'b0);
    @(negedge clk);
    chk("byp_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("byp_2cyc", 32'(out_valid), 32'd1);
    collect(vc);
    push(16'h8000, 16'hFFFF, 4'd9, 1'b0);
    collect(vc);
    chk("byp_no_start", 32'(starts - s0), 32'd0);

    dlat = 4;
    for (int i = 0; i < 5; i++)
      push(16'(100 + i), 16'd3, 4'(i + 1), 1'b0);
    repeat (30) @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    hq = out_quotient;
    ht = out_tag;
    repeat (5) @(negedge clk);
    chk("hold_q",   32'(out_quotient), 32'(hq));
    chk("hold_tag", 32'(out_tag),      32'(ht));
    fork
      push(16'd200, 16'd9, 4'd6, 1'b0);
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) collect(vc);
      end
    join
    chk("drained", 32'(exp_q.size()), 32'd0);

    for (int it = 0; it < 30; it++) begin
      dlat = $urandom_range(3, 40);
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        case ($urandom_range(0, 9))
          0: rb = '0;
          1: begin ra = 16'h8000; rb = 16'hFFFF; end
          2: rb = 16'hFFFF;
          3: rb = W'($signed(4'($urandom)));
          default: ;
        endcase
        push(ra, rb, 4'($urandom), 1'b0);
      end
      for (int j = 0; j < k; j++) collect(vc);
    end

    hang = 1'b1;
    push(16'd77, 16'd5, 4'hA, 1'b1);
    collect(vc);
    chk("wd_cycles", 32'(vc - start_cyc), 32'd65);
    hang = 1'b0;
    repeat (5) @(negedge clk);

    hang = 1'b1;
    s0 = starts;
    push(16'd50, 16'd4, 4'hB, 1'b0);
    push(16'd60, 16'd4, 4'hC, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    rst = 1'b0;
    hang = 1'b0;
    exp_q.delete();
    k = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) k++;
    end
    chk("rst_no_result", 32'(k), 32'd0);
    chk("rst_fifo_empty", 32'(starts - s0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
